// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter
//   Shares one downstream memory port between an iCache refill requester and
//   a dCache requester. A three-state FSM (IDLE -> REQ -> RESP) holds one
//   transaction at a time.
//   - Arbitration is round-robin by default. The dCache wins the first tie
//     after reset.
//   - Defining L2_ARB_DC_PRIORITY_EN switches to fixed priority, with the
//     dCache always winning over the iCache.
//   - Each response beat is registered once and steered to the requester
//     that owns the outstanding transaction.
//   - iCache refills take IC_BEATS beats. dCache transactions take one beat.
//
// Ports
//   clk_i, rstn_i       clock, asynchronous active-low reset
//   ic_req_*            iCache refill request (26-bit line address) / ready
//   ic_rsp_*            iCache beat valid, data, beat index
//   dc_req_*            dCache request (addr, cmd, tag) / ready
//   dc_rsp_*            dCache response valid, data, tag
//   mem_req_*           downstream request (valid/ready, addr, cmd, tag, src)
//   mem_rsp_*           downstream response beat
//   spurious_rsp_o      sticky flag: a beat arrived with nothing outstanding
module l2_req_arbiter #(
  parameter int LINE_SIZE = 128,
  parameter int IC_BEATS  = 4
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         ic_req_valid_i,
  input  logic [25:0]                  ic_req_addr_i,
  output logic                         ic_req_ready_o,
  output logic                         ic_rsp_valid_o,
  output logic [LINE_SIZE-1:0]         ic_rsp_data_o,
  output logic [$clog2(IC_BEATS)-1:0]  ic_rsp_seq_o,
  input  logic                         dc_req_valid_i,
  input  logic [31:0]                  dc_req_addr_i,
  input  logic [4:0]                   dc_req_cmd_i,
  input  logic [7:0]                   dc_req_tag_i,
  output logic                         dc_req_ready_o,
  output logic                         dc_rsp_valid_o,
  output logic [LINE_SIZE-1:0]         dc_rsp_data_o,
  output logic [7:0]                   dc_rsp_tag_o,
  output logic                         mem_req_valid_o,
  input  logic                         mem_req_ready_i,
  output logic [31:0]                  mem_req_addr_o,
  output logic [4:0]                   mem_req_cmd_o,
  output logic [7:0]                   mem_req_tag_o,
  output logic                         mem_req_src_o,
  input  logic                         mem_rsp_valid_i,
  input  logic [LINE_SIZE-1:0]         mem_rsp_data_i,
  output logic                         spurious_rsp_o
);

  localparam int SEQ_W = $clog2(IC_BEATS);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

  state_t               state_q, state_d;
  logic                 grant_ic, grant_dc;
  logic                 rsp_beat, last_beat;

  // Latched request fields. They stay stable through REQ and RESP.
  logic [31:0]          addr_q;
  logic [4:0]           cmd_q;
  logic [7:0]           tag_q;
  logic                 src_q;
  logic [SEQ_W-1:0]     beat_cnt_q;
  logic                 spurious_q;

  // Registered response beat.
  logic                 ic_vld_p1, dc_vld_p1;
  logic [LINE_SIZE-1:0] rsp_data_p1;
  logic [SEQ_W-1:0]     seq_p1;

`ifndef L2_ARB_DC_PRIORITY_EN
  logic                 last_ic_q;
`endif

  // Grant decision. Only taken in IDLE.
  always_comb begin
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (state_q == ST_IDLE) begin
`ifdef L2_ARB_DC_PRIORITY_EN
      if (dc_req_valid_i)      grant_dc = 1'b1;
      else if (ic_req_valid_i) grant_ic = 1'b1;
`else
      if (dc_req_valid_i && ic_req_valid_i) begin
        // On a tie, the requester that was not served last wins.
        if (last_ic_q) grant_dc = 1'b1;
        else           grant_ic = 1'b1;
      end else if (dc_req_valid_i) begin
        grant_dc = 1'b1;
      end else if (ic_req_valid_i) begin
        grant_ic = 1'b1;
      end
`endif
    end
  end

  assign rsp_beat  = (state_q == ST_RESP) && mem_rsp_valid_i;
  // A dCache transaction ends on its only beat. An iCache refill ends on beat IC_BEATS-1.
  assign last_beat = rsp_beat && (!src_q || (beat_cnt_q == SEQ_W'(IC_BEATS - 1)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_ic || grant_dc) state_d = ST_REQ;
      ST_REQ:  if (mem_req_ready_i)      state_d = ST_RESP;
      ST_RESP: if (last_beat)            state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Request latch and arbitration history.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_q <= '0;
      cmd_q  <= '0;
      tag_q  <= '0;
      src_q  <= 1'b0;
`ifndef L2_ARB_DC_PRIORITY_EN
      last_ic_q <= 1'b1;
`endif
    end else if (grant_ic) begin
      addr_q <= {ic_req_addr_i, 6'b0};
      cmd_q  <= '0;
      tag_q  <= '0;
      src_q  <= 1'b1;
`ifndef L2_ARB_DC_PRIORITY_EN
      last_ic_q <= 1'b1;
`endif
    end else if (grant_dc) begin
      addr_q <= dc_req_addr_i;
      cmd_q  <= dc_req_cmd_i;
      tag_q  <= dc_req_tag_i;
      src_q  <= 1'b0;
`ifndef L2_ARB_DC_PRIORITY_EN
      last_ic_q <= 1'b0;
`endif
    end
  end

  // Response stage p0 -> p1: register the beat and steer it by source.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ic_vld_p1   <= 1'b0;
      dc_vld_p1   <= 1'b0;
      rsp_data_p1 <= '0;
      seq_p1      <= '0;
      beat_cnt_q  <= '0;
      spurious_q  <= 1'b0;
    end else begin
      ic_vld_p1   <= rsp_beat && src_q;
      dc_vld_p1   <= rsp_beat && !src_q;
      rsp_data_p1 <= rsp_beat ? mem_rsp_data_i : '0;
      if (rsp_beat && src_q) begin
        seq_p1     <= beat_cnt_q;
        beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 1'b1;
      end
      if (mem_rsp_valid_i && (state_q != ST_RESP)) spurious_q <= 1'b1;
    end
  end

  assign ic_req_ready_o  = grant_ic;
  assign dc_req_ready_o  = grant_dc;
  assign mem_req_valid_o = (state_q == ST_REQ);
  assign mem_req_addr_o  = addr_q;
  assign mem_req_cmd_o   = cmd_q;
  assign mem_req_tag_o   = tag_q;
  assign mem_req_src_o   = src_q;

  assign ic_rsp_valid_o  = ic_vld_p1;
  assign ic_rsp_data_o   = ic_vld_p1 ? rsp_data_p1 : '0;
  assign ic_rsp_seq_o    = seq_p1;
  assign dc_rsp_valid_o  = dc_vld_p1;
  assign dc_rsp_data_o   = dc_vld_p1 ? rsp_data_p1 : '0;
  assign dc_rsp_tag_o    = tag_q;
  assign spurious_rsp_o  = spurious_q;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed bench for l2_req_arbiter with hand-computed expectations.
module tb_l2_req_arbiter;

  localparam int LS = 128;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ic_req_valid;
  logic [25:0]   ic_req_addr;
  logic          ic_req_ready;
  logic          ic_rsp_valid;
  logic [LS-1:0] ic_rsp_data;
  logic [1:0]    ic_rsp_seq;
  logic          dc_req_valid;
  logic [31:0]   dc_req_addr;
  logic [4:0]    dc_req_cmd;
  logic [7:0]    dc_req_tag;
  logic          dc_req_ready;
  logic          dc_rsp_valid;
  logic [LS-1:0] dc_rsp_data;
  logic [7:0]    dc_rsp_tag;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [31:0]   mem_req_addr;
  logic [4:0]    mem_req_cmd;
  logic [7:0]    mem_req_tag;
  logic          mem_req_src;
  logic          mem_rsp_valid;
  logic [LS-1:0] mem_rsp_data;
  logic          spurious_rsp;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  l2_req_arbiter #(.LINE_SIZE(LS), .IC_BEATS(4)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .ic_req_valid_i(ic_req_valid), .ic_req_addr_i(ic_req_addr), .ic_req_ready_o(ic_req_ready),
    .ic_rsp_valid_o(ic_rsp_valid), .ic_rsp_data_o(ic_rsp_data), .ic_rsp_seq_o(ic_rsp_seq),
    .dc_req_valid_i(dc_req_valid), .dc_req_addr_i(dc_req_addr), .dc_req_cmd_i(dc_req_cmd),
    .dc_req_tag_i(dc_req_tag), .dc_req_ready_o(dc_req_ready),
    .dc_rsp_valid_o(dc_rsp_valid), .dc_rsp_data_o(dc_rsp_data), .dc_rsp_tag_o(dc_rsp_tag),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_req_addr_o(mem_req_addr), .mem_req_cmd_o(mem_req_cmd), .mem_req_tag_o(mem_req_tag),
    .mem_req_src_o(mem_req_src), .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_data_i(mem_rsp_data),
    .spurious_rsp_o(spurious_rsp)
  );

  task automatic chk(input string tag, input logic [LS-1:0] got, input logic [LS-1:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serve one grant with both requesters asserting; report who won.
  task automatic serve(output bit got_dc);
    int nb;
    chk("rr_one_ready", LS'(dc_req_ready ^ ic_req_ready), LS'(1));
    got_dc = dc_req_ready;
    step();
    chk("rr_req_no_ready", LS'(dc_req_ready | ic_req_ready), LS'(0));
    step();
    chk("rr_resp_no_ready", LS'(dc_req_ready | ic_req_ready), LS'(0));
    nb = got_dc ? 1 : 4;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = LS'(32'h600D);
    for (int b = 0; b < nb; b++) step();
    mem_rsp_valid = 1'b0;
  endtask

  bit got_dc;
  bit exp_dc;
  logic [LS-1:0] dbeat;

  initial begin
    rstn = 1'b0; ic_req_valid = 0; ic_req_addr = '0; dc_req_valid = 0; dc_req_addr = '0;
    dc_req_cmd = '0; dc_req_tag = '0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
    #12;
    chk("rst_mem_valid", LS'(mem_req_valid), LS'(0));
    chk("rst_mem_addr", LS'(mem_req_addr), LS'(0));
    chk("rst_spurious", LS'(spurious_rsp), LS'(0));
    step();
    rstn = 1'b1;
    step();

    // dCache single-beat transaction
    dc_req_valid = 1; dc_req_addr = 32'h8000_1230; dc_req_cmd = 5'h03; dc_req_tag = 8'h5A;
    mem_req_ready = 1;
    #1;
    chk("dc_ready_c0", LS'(dc_req_ready), LS'(1));
    chk("dc_ic_ready_c0", LS'(ic_req_ready), LS'(0));
    step();
    dc_req_valid = 0;
    chk("dc_mem_valid", LS'(mem_req_valid), LS'(1));
    chk("dc_mem_addr", LS'(mem_req_addr), LS'(32'h8000_1230));
    chk("dc_mem_cmd", LS'(mem_req_cmd), LS'(3));
    chk("dc_mem_tag", LS'(mem_req_tag), LS'(8'h5A));
    chk("dc_mem_src", LS'(mem_req_src), LS'(0));
    step();
    chk("dc_resp_mem_valid", LS'(mem_req_valid), LS'(0));
    mem_rsp_valid = 1; mem_rsp_data = LS'(8'hAB);
    step();
    mem_rsp_valid = 0;
    chk("dc_rsp_valid", LS'(dc_rsp_valid), LS'(1));
    chk("dc_rsp_data", dc_rsp_data, LS'(8'hAB));
    chk("dc_rsp_tag", LS'(dc_rsp_tag), LS'(8'h5A));
    chk("dc_ic_rsp_quiet", LS'(ic_rsp_valid), LS'(0));
    step();
    chk("dc_rsp_valid_drop", LS'(dc_rsp_valid), LS'(0));
    chk("dc_rsp_data_zero", dc_rsp_data, LS'(0));

    // iCache 4-beat refill
    ic_req_valid = 1; ic_req_addr = 26'h0000040;
    #1;
    chk("ic_ready_c0", LS'(ic_req_ready), LS'(1));
    step();
    ic_req_valid = 0;
    chk("ic_mem_addr", LS'(mem_req_addr), LS'(32'h0000_1000));
    chk("ic_mem_src", LS'(mem_req_src), LS'(1));
    chk("ic_mem_cmd", LS'(mem_req_cmd), LS'(0));
    chk("ic_mem_tag", LS'(mem_req_tag), LS'(0));
    step();
    for (int i = 0; i < 4; i++) begin
      dbeat = {32'hD0D0_0000 + 32'(i), 96'h0};
      mem_rsp_valid = 1; mem_rsp_data = dbeat;
      step();
      chk($sformatf("ic_valid_b%0d", i), LS'(ic_rsp_valid), LS'(1));
      chk($sformatf("ic_seq_b%0d", i), LS'(ic_rsp_seq), LS'(i));
      chk($sformatf("ic_data_b%0d", i), ic_rsp_data, dbeat);
      chk($sformatf("ic_dc_quiet_b%0d", i), LS'(dc_rsp_valid), LS'(0));
    end
    mem_rsp_valid = 0;
    step();
    chk("ic_valid_after4", LS'(ic_rsp_valid), LS'(0));
    chk("ic_data_after4", ic_rsp_data, LS'(0));
    chk("ic_no_spurious", LS'(spurious_rsp), LS'(0));

    // Both requesters continuously; last grant was iCache, so dCache wins first
    dc_req_valid = 1; ic_req_valid = 1;
    dc_req_addr = 32'h0000_2000; dc_req_tag = 8'h01; ic_req_addr = 26'h10;
    #1;
    for (int g = 0; g < 4; g++) begin
`ifdef L2_ARB_DC_PRIORITY_EN
      exp_dc = 1'b1;
`else
      exp_dc = (g % 2) == 0;
`endif
      serve(got_dc);
      chk($sformatf("rr_grant%0d_dc", g), LS'(got_dc), LS'(exp_dc));
    end
    dc_req_valid = 0; ic_req_valid = 0;
    step();

    // Downstream stall: request must hold steady, no readies
    mem_req_ready = 0;
    dc_req_valid = 1; dc_req_addr = 32'h1234_5678; dc_req_cmd = 5'h11; dc_req_tag = 8'h33;
    step();
    dc_req_addr = 32'hFFFF_0000; dc_req_cmd = 5'h1F; dc_req_tag = 8'hEE; ic_req_valid = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall_valid%0d", c), LS'(mem_req_valid), LS'(1));
      chk($sformatf("stall_addr%0d", c), LS'(mem_req_addr), LS'(32'h1234_5678));
      chk($sformatf("stall_tag%0d", c), LS'(mem_req_tag), LS'(8'h33));
      chk($sformatf("stall_cmd%0d", c), LS'(mem_req_cmd), LS'(5'h11));
      chk($sformatf("stall_ready%0d", c), LS'(dc_req_ready | ic_req_ready), LS'(0));
      step();
    end
    dc_req_valid = 0; ic_req_valid = 0; mem_req_ready = 1;
    step();
    mem_rsp_valid = 1; mem_rsp_data = LS'(8'h77);
    step();
    mem_rsp_valid = 0;
    chk("stall_rsp_data", dc_rsp_data, LS'(8'h77));
    chk("stall_rsp_tag", LS'(dc_rsp_tag), LS'(8'h33));
    step();

    // Spurious beat in IDLE
    mem_rsp_valid = 1; mem_rsp_data = LS'(8'hFF);
    step();
    mem_rsp_valid = 0;
    chk("spur_no_dc", LS'(dc_rsp_valid), LS'(0));
    chk("spur_no_ic", LS'(ic_rsp_valid), LS'(0));
    chk("spur_data_zero", dc_rsp_data | ic_rsp_data, LS'(0));
    chk("spur_flag", LS'(spurious_rsp), LS'(1));
    step(); step();
    chk("spur_sticky", LS'(spurious_rsp), LS'(1));

    // Reset mid-refill after beat 1
    ic_req_valid = 1; ic_req_addr = 26'h2;
    step();
    ic_req_valid = 0;
    step();
    mem_rsp_valid = 1; mem_rsp_data = LS'(32'hB0);
    step();
    mem_rsp_data = LS'(32'hB1);
    step();
    chk("mid_seq1", LS'(ic_rsp_seq), LS'(1));
    rstn = 1'b0;
    mem_rsp_data = LS'(32'hB2);
    #1;
    chk("mid_rst_ic_valid", LS'(ic_rsp_valid), LS'(0));
    chk("mid_rst_ic_data", ic_rsp_data, LS'(0));
    chk("mid_rst_seq", LS'(ic_rsp_seq), LS'(0));
    chk("mid_rst_mem_valid", LS'(mem_req_valid), LS'(0));
    chk("mid_rst_mem_addr", LS'(mem_req_addr), LS'(0));
    chk("mid_rst_mem_src", LS'(mem_req_src), LS'(0));
    chk("mid_rst_spurious", LS'(spurious_rsp), LS'(0));
    step();
    rstn = 1'b1;
    step();
    mem_rsp_data = LS'(32'hB3);
    chk("post_rst_ic_valid0", LS'(ic_rsp_valid), LS'(0));
    step();
    mem_rsp_valid = 0;
    chk("post_rst_ic_valid1", LS'(ic_rsp_valid), LS'(0));
    chk("post_rst_dc_valid", LS'(dc_rsp_valid), LS'(0));
    dc_req_valid = 1; ic_req_valid = 1; dc_req_addr = 32'h40; dc_req_tag = 8'h09;
    #1;
    chk("post_rst_tie_dc", LS'(dc_req_ready), LS'(1));
    chk("post_rst_tie_ic", LS'(ic_req_ready), LS'(0));
    step();
    dc_req_valid = 0; ic_req_valid = 0;
    chk("post_rst_src", LS'(mem_req_src), LS'(0));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_req_arbiter.md
L2_REQ_ARBITER -- requirements
Module: l2_req_arbiter

Interface
REQ-001 Parameter LINE_SIZE, default 128, SHALL set the response data width in bits.
REQ-002 Parameter IC_BEATS, default 4, SHALL set the number of beats in an iCache line refill; it SHALL be a power of two, 2 to 16.
REQ-003 The ports SHALL be, one per line: name  direction  width  meaning.
  clk_i  in  1  single clock; all state on rising edge
  rstn_i  in  1  reset, asynchronous, active-low
  ic_req_valid_i  in  1  iCache refill request
  ic_req_addr_i  in  26  iCache line address
  ic_req_ready_o  out  1  iCache request accepted this cycle
  ic_rsp_valid_o  out  1  iCache beat valid
  ic_rsp_data_o  out  LINE_SIZE  iCache beat data
  ic_rsp_seq_o  out  log2(IC_BEATS)  beat index
  dc_req_valid_i  in  1  dCache request
  dc_req_addr_i  in  32  dCache byte address
  dc_req_cmd_i  in  5  dCache command
  dc_req_tag_i  in  8  dCache tag
  dc_req_ready_o  out  1  dCache request accepted this cycle
  dc_rsp_valid_o  out  1  dCache response valid
  dc_rsp_data_o  out  LINE_SIZE  dCache response data
  dc_rsp_tag_o  out  8  returned tag
  mem_req_valid_o  out  1  downstream request valid
  mem_req_ready_i  in  1  downstream accepts request
  mem_req_addr_o  out  32  downstream address
  mem_req_cmd_o  out  5  downstream command
  mem_req_tag_o  out  8  downstream tag
  mem_req_src_o  out  1  requester: 0 = dCache, 1 = iCache
  mem_rsp_valid_i  in  1  downstream response beat
  mem_rsp_data_i  in  LINE_SIZE  downstream response data
  spurious_rsp_o  out  1  sticky flag: response beat received with no request outstanding

Function
REQ-004 The block SHALL implement a finite-state machine with three states.
  IDLE: no request held.
  REQ: mem_req_valid_o = 1; waiting for mem_req_ready_i.
  RESP: waiting for response beats.
REQ-005 In IDLE, with at least one *_req_valid_i high, the block SHALL grant exactly one requester. It SHALL assert that requester's *_req_ready_o combinationally in the same cycle, latch its fields, and move to REQ.
REQ-006 The *_req_ready_o outputs SHALL be 0 in REQ and RESP.
REQ-007 Arbitration SHALL be round-robin: a sole requester wins; on simultaneous requests the requester not granted last wins. The last-granted register SHALL reset to iCache, so the dCache wins the first tie.
REQ-008 For an iCache grant, the downstream fields SHALL be:
  mem_req_addr_o = {ic_req_addr_i, 6'b0}
  mem_req_cmd_o = 0
  mem_req_tag_o = 0
  mem_req_src_o = 1
REQ-009 For a dCache grant, mem_req_addr_o, mem_req_cmd_o and mem_req_tag_o SHALL equal the latched dCache values, and mem_req_src_o SHALL be 0.
REQ-010 The mem_req_* outputs SHALL hold stable while in REQ. The block SHALL move REQ -> RESP in the cycle mem_req_valid_o and mem_req_ready_i are both 1.
REQ-011 In RESP, each mem_rsp_valid_i beat SHALL be registered and presented one cycle later on the src-selected response port, with *_rsp_valid_o high for exactly one cycle. The other port's valid SHALL stay 0.
REQ-012 iCache beats SHALL be counted from 0. ic_rsp_seq_o SHALL carry the beat count, which increments per beat.
  The block SHALL return to IDLE on beat IC_BEATS-1, and the counter SHALL wrap to 0.
REQ-013 dc_rsp_tag_o SHALL equal the latched tag. A dCache transaction SHALL complete on its first beat, returning to IDLE.
REQ-014 A new grant SHALL be possible in the cycle after the return to IDLE. The minimum request-to-request spacing SHALL be therefore 3 cycles for dCache.
REQ-015 mem_rsp_valid_i while in IDLE or REQ SHALL be dropped. It SHALL set spurious_rsp_o, which stays 1 until reset.
REQ-016 Response data outputs SHALL be 0 whenever the corresponding valid is 0.

Reset
REQ-017 While rstn_i = 0, the block SHALL clear the following immediately and asynchronously:
  - state to IDLE
  - last-granted to iCache
  - beat counter, all latched fields, all outputs and spurious_rsp_o to 0
REQ-018 A reset asserted mid-transaction SHALL abandon the transaction. No response for it SHALL be forwarded after reset deassertion.

Configuration
REQ-019 With macro L2_ARB_DC_PRIORITY_EN defined, arbitration SHALL be fixed priority, dCache over iCache, and last-granted SHALL be unused. Undefined, REQ-007 round-robin SHALL apply.

Verification
REQ-020 The bench SHALL cover:
  - Reset, then dc_req_valid_i = 1, addr 0x80001230, tag 0x5A, mem_req_ready_i = 1, one beat 0xAB -> dc_req_ready_o in cycle 0; mem_req_addr_o = 0x80001230, src = 0; dc_rsp_valid_o one cycle after the beat with data 0xAB, tag 0x5A.
  - ic_req_addr_i = 0x0000040, four beats D0..D3 -> mem_req_addr_o = 0x00001000, src = 1; ic_rsp_seq_o 0,1,2,3; ic_rsp_valid_o high for exactly 4 cycles.
  - Both requesting continuously, round-robin -> grants alternate dc, ic, dc, ic. With L2_ARB_DC_PRIORITY_EN -> dc every time.
  - mem_req_ready_i held 0 for 5 cycles -> mem_req_* stable; no *_req_ready_o asserted.
  - mem_rsp_valid_i pulsed in IDLE -> no rsp valid; spurious_rsp_o = 1 until reset.
  - rstn_i pulsed low after beat 1 of an iCache refill -> all outputs 0; later beats ignored; next tie grants dCache.
